// File: rtl/dec_stage_2.sv
// Extended-Hamming (SECDED) decoder for 8/16/32-bit codewords with saturating error counters.
// Two register stages (syndrome, correction); a stalled output stage holds its result and back-pressures input.
module dec_stage_2 #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          cnt_single,
    output logic [CNT_WIDTH-1:0]          cnt_double
);

    localparam logic [31:0] R00_1 = 32'h0000_00E4;
    localparam logic [31:0] R00_2 = 32'h0000_00D2;
    localparam logic [31:0] R00_3 = 32'h0000_00B1;
    localparam logic [31:0] R01_1 = 32'h0000_FE08;
    localparam logic [31:0] R01_2 = 32'h0000_F1C4;
    localparam logic [31:0] R01_3 = 32'h0000_CDA2;
    localparam logic [31:0] R01_4 = 32'h0000_AB61;
    localparam logic [31:0] R10_1 = 32'hFFFE_0010;
    localparam logic [31:0] R10_2 = 32'hFF01_FC08;
    localparam logic [31:0] R10_3 = 32'hF0F1_E384;
    localparam logic [31:0] R10_4 = 32'hCCCD_9B42;
    localparam logic [31:0] R10_5 = 32'hAAAB_56C1;

    // Syndrome bits right-aligned: the first row of each mode is the syndrome MSB.
    function automatic logic [4:0] column(input logic [1:0] m, input logic [4:0] j);
        case (m)
            2'b00:   column = {2'b00, R00_1[j], R00_2[j], R00_3[j]};
            2'b01:   column = {1'b0, R01_1[j], R01_2[j], R01_3[j], R01_4[j]};
            2'b10:   column = {R10_1[j], R10_2[j], R10_3[j], R10_4[j], R10_5[j]};
            default: column = 5'd0;
        endcase
    endfunction

    logic                          adv1, adv2;
    logic                          s1_vld, s1_par, s2_vld;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_dat;
    logic [1:0]                    s1_mod;
    logic [4:0]                    s1_syn;
    logic [4:0]                    syn;
    logic                          par;
    logic [31:0]                   flip, fixed;
    logic                          hit;
    logic [MAX_INFO_WIDTH-1:0]     info;
    logic [1:0]                    nerr;

    assign adv2      = !s2_vld || out_ready;
    assign adv1      = !s1_vld || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_vld;

    always_comb begin
        syn = 5'd0;
        par = 1'b0;
        case (mod)
            2'b00: begin
                syn = {2'b00, ^(data_in & R00_1), ^(data_in & R00_2), ^(data_in & R00_3)};
                par = ^data_in[7:0];
            end
            2'b01: begin
                syn = {1'b0, ^(data_in & R01_1), ^(data_in & R01_2), ^(data_in & R01_3),
                       ^(data_in & R01_4)};
                par = ^data_in[15:0];
            end
            2'b10: begin
                syn = {^(data_in & R10_1), ^(data_in & R10_2), ^(data_in & R10_3),
                       ^(data_in & R10_4), ^(data_in & R10_5)};
                par = ^data_in;
            end
            default: begin
                syn = 5'd0;
                par = 1'b0;
            end
        endcase
    end

    always_comb begin
        flip = 32'd0;
        hit  = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (s1_syn != 5'd0 && column(s1_mod, j[4:0]) == s1_syn) begin
                flip[j] = 1'b1;
                hit     = 1'b1;
            end
        end
        // Only an odd overall parity means a single, correctable error.
        fixed = s1_par ? (s1_dat ^ flip) : s1_dat;
        if (s1_mod == 2'b11)                       nerr = 2'd3;
        else if (s1_syn == 5'd0 && !s1_par)        nerr = 2'd0;
        else if (s1_par && (s1_syn == 5'd0 || hit)) nerr = 2'd1;
        else                                       nerr = 2'd2;
        case (s1_mod)
            2'b00:   info = {22'd0, fixed[7:4]};
            2'b01:   info = {15'd0, fixed[15:5]};
            2'b10:   info = fixed[31:6];
            default: info = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_mod <= 2'b00;
            s1_syn <= 5'd0;
            s1_par <= 1'b0;
        end else if (adv1) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat <= data_in;
                s1_mod <= mod;
                s1_syn <= syn;
                s1_par <= par;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld        <= 1'b0;
            data_out      <= '0;
            num_of_errors <= 2'd0;
        end else if (adv2) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                data_out      <= info;
                num_of_errors <= nerr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_valid && out_ready) begin
            if (num_of_errors == 2'd1 && cnt_single != {CNT_WIDTH{1'b1}})
                cnt_single <= cnt_single + 1'b1;
            if (num_of_errors == 2'd2 && cnt_double != {CNT_WIDTH{1'b1}})
                cnt_double <= cnt_double + 1'b1;
        end
    end

endmodule
